lu_arbiter: RTL and testbench

Two-requester scheduler that shares one bitwise logic unit (NAND/NOR/AND/OR selected by a two-level mux tree) between independent clients. It accepts one operation at a time via a req/gnt handshake, drives the unit's select lines, registers the result, and returns it via a valid/ready handshake. It sits between the client blocks and the combinational logic unit and is the only driver of the unit's select inputs.

---
 rtl/lu_pkg.sv | 23 ++
 rtl/lu_core.sv | 27 ++
 rtl/lu_arbiter.sv | 147 ++++++++++++++
 tb/tb_lu_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lu_pkg.sv
// Shared types and constants for the lu_arbiter logic-unit scheduler.
package lu_pkg;

   localparam int unsigned LU_WIDTH = 4;
   localparam int unsigned N_REQ    = 2;

   typedef logic [1:0] op_t;

   // op[1] selects the group (inverting / non-inverting), op[0] selects within it
   localparam op_t OP_NAND = 2'b00;
   localparam op_t OP_NOR  = 2'b01;
   localparam op_t OP_AND  = 2'b10;
   localparam op_t OP_OR   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef logic req_idx_t;

endpackage

// File: rtl/lu_core.sv
// Combinational bitwise logic unit: NAND/NOR/AND/OR via a two-level 2:1 mux tree.
module lu_core
   import lu_pkg::*;
#(
   parameter int unsigned WIDTH = LU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] res_c
);

   logic [WIDTH-1:0] and_v;
   logic [WIDTH-1:0] or_v;
   logic [WIDTH-1:0] inv_grp;
   logic [WIDTH-1:0] pos_grp;

   // First level picks within a group, second level picks the group
   always_comb begin
      and_v   = a & b;
      or_v    = a | b;
      inv_grp = op[0] ? ~or_v : ~and_v;
      pos_grp = op[0] ? or_v  : and_v;
      res_c   = op[1] ? pos_grp : inv_grp;
   end

endmodule

// File: rtl/lu_arbiter.sv
// Two-requester scheduler for the shared logic unit.
// Optional build macro LU_ARB_RR_EN: round-robin arbitration on simultaneous
// requests (otherwise requester 0 has fixed priority).
module lu_arbiter
   import lu_pkg::*;
#(
   parameter int unsigned WIDTH = LU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  op_t              op0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  op_t              op1,
   output logic [1:0]       gnt,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy
);

   state_e           state_q,     state_d;
   logic [1:0]       gnt_q,       gnt_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
   logic             busy_q,      busy_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   op_t              op_q,        op_d;
   req_idx_t         winner_q,    winner_d;
   req_idx_t         pick_c;
   logic [WIDTH-1:0] lu_res_c;

`ifdef LU_ARB_RR_EN
   req_idx_t         last_winner_q, last_winner_d;
`endif

   lu_core #(.WIDTH(WIDTH)) u_core (
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
      .res_c (lu_res_c)
   );

   // Arbitration: which requester wins if we grant this cycle
   always_comb begin
      pick_c = ~req[0];
`ifdef LU_ARB_RR_EN
      if (req == 2'b11) begin
         pick_c = ~last_winner_q;
      end
`endif
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      gnt_d       = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      winner_d    = winner_q;
`ifdef LU_ARB_RR_EN
      last_winner_d = last_winner_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               winner_d      = pick_c;
               gnt_d[pick_c] = 1'b1;
               a_d           = pick_c ? a1  : a0;
               b_d           = pick_c ? b1  : b0;
               op_d          = pick_c ? op1 : op0;
               state_d       = EXEC;
`ifdef LU_ARB_RR_EN
               last_winner_d = pick_c;
`endif
            end
         end
         EXEC: begin
            rsp_data_d            = lu_res_c;
            rsp_valid_d           = '0;
            rsp_valid_d[winner_q] = 1'b1;
            state_d               = RESP;
         end
         RESP: begin
            // Only the winner's ready completes the response
            if (rsp_ready[winner_q]) begin
               rsp_valid_d = '0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_NAND;
         winner_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         busy_q      <= busy_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         winner_q    <= winner_d;
      end
   end

`ifdef LU_ARB_RR_EN
   // Arbitration history; reset value makes requester 0 win first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_winner_q <= 1'b1;
      end else begin
         last_winner_q <= last_winner_d;
      end
   end
`endif

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed testbench for lu_arbiter (table-driven opcode vectors plus
// hand-written multi-cycle sequences).
`timescale 1ns/1ps
module tb_lu_arbiter;
   import lu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] req = '0;
   logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   op_t        op0 = OP_NAND, op1 = OP_NAND;
   logic [1:0] gnt, rsp_valid;
   logic [1:0] rsp_ready = '0;
   logic [3:0] rsp_data;
   logic       busy;

   int total  = 0;
   int passed = 0;

   lu_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rq;
      logic [3:0] a;
      logic [3:0] b;
      op_t        op;
      logic [3:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_gnt"},   32'(gnt),       32'h0);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'h0);
      chk({tag, "_data"},  32'(rsp_data),  32'h0);
      chk({tag, "_busy"},  32'(busy),      32'h0);
   endtask

   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   vec_t       vecs[10];
   logic [1:0] exp_seq[4];
   logic [1:0] bit_r;
   bit         found;

   initial begin
      // Hand-computed vectors
      vecs[0] = '{1'b1, 4'b1100, 4'b1010, OP_NAND, 4'b0111};
      vecs[1] = '{1'b1, 4'b1100, 4'b1010, OP_NOR,  4'b0001};
      vecs[2] = '{1'b1, 4'b1100, 4'b1010, OP_AND,  4'b1000};
      vecs[3] = '{1'b1, 4'b1100, 4'b1010, OP_OR,   4'b1110};
      vecs[4] = '{1'b0, 4'b1111, 4'b0000, OP_NAND, 4'b1111};
      vecs[5] = '{1'b0, 4'b1111, 4'b0000, OP_NOR,  4'b0000};
      vecs[6] = '{1'b0, 4'b0110, 4'b0011, OP_AND,  4'b0010};
      vecs[7] = '{1'b0, 4'b0110, 4'b0011, OP_OR,   4'b0111};
      vecs[8] = '{1'b1, 4'b1111, 4'b1111, OP_NAND, 4'b0000};
      vecs[9] = '{1'b1, 4'b0000, 4'b0000, OP_NOR,  4'b1111};

      // Power-on reset: outputs clear without a clock edge
      #2 rst_n = 1'b0;
      #1 chk_idle_outputs("por");
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single AND request from requester 0 with ready held low
      req = 2'b01; a0 = 4'b1100; b0 = 4'b1010; op0 = OP_AND;
      step();
      chk("and_gnt",  32'(gnt),  32'h1);
      chk("and_busy", 32'(busy), 32'h1);
      req = 2'b00;
      step();
      chk("and_gnt_pulse", 32'(gnt),       32'h0);
      chk("and_valid",     32'(rsp_valid), 32'h1);
      chk("and_data",      32'(rsp_data),  32'h8);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("and_hold_valid", 32'(rsp_valid), 32'h1);
         chk("and_hold_data",  32'(rsp_data),  32'h8);
      end

      // Reset while in RESP: outputs drop asynchronously
      #2 rst_n = 1'b0;
      #1 chk_idle_outputs("rst_resp");
      rst_n = 1'b1;
      step();

      // After reset both requesters ask; requester 0 must win first
      req = 2'b11;
      a0 = 4'b0110; b0 = 4'b0011; op0 = OP_OR;
      a1 = 4'b1111; b1 = 4'b1111; op1 = OP_AND;
      step();
      chk("post_rst_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      step();
      chk("post_rst_valid", 32'(rsp_valid), 32'h1);
      chk("post_rst_data",  32'(rsp_data),  32'h7);
      rsp_ready = 2'b01;
      step();
      chk("post_rst_done", 32'(rsp_valid), 32'h0);
      rsp_ready = 2'b00;

      // Table-driven opcode vectors, one requester at a time
      foreach (vecs[i]) begin
         bit_r = vecs[i].rq ? 2'b10 : 2'b01;
         if (vecs[i].rq) begin
            a1 = vecs[i].a; b1 = vecs[i].b; op1 = vecs[i].op;
            a0 = ~vecs[i].a; b0 = ~vecs[i].b; op0 = ~vecs[i].op;
         end else begin
            a0 = vecs[i].a; b0 = vecs[i].b; op0 = vecs[i].op;
            a1 = ~vecs[i].a; b1 = ~vecs[i].b; op1 = ~vecs[i].op;
         end
         req = bit_r;
         step();
         chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(bit_r));
         req = 2'b00;
         step();
         chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'(bit_r));
         chk($sformatf("vec%0d_data", i),  32'(rsp_data),  32'(vecs[i].exp));
         rsp_ready = bit_r;
         step();
         chk($sformatf("vec%0d_done", i), 32'(rsp_valid), 32'h0);
         chk($sformatf("vec%0d_idle", i), 32'(busy),      32'h0);
         rsp_ready = 2'b00;
      end

      // Cross-requester ready is ignored; pending req[1] granted after return
      a0 = 4'b1100; b0 = 4'b1010; op0 = OP_AND;
      a1 = 4'b1100; b1 = 4'b1010; op1 = OP_NOR;
      req = 2'b01;
      step();
      chk("cross_gnt0", 32'(gnt), 32'h1);
      req = 2'b10;
      step();
      chk("cross_valid0", 32'(rsp_valid), 32'h1);
      rsp_ready = 2'b10;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("cross_ignore_valid", 32'(rsp_valid), 32'h1);
         chk("cross_no_gnt",       32'(gnt),       32'h0);
      end
      rsp_ready = 2'b01;
      step();
      chk("cross_ret_valid", 32'(rsp_valid), 32'h0);
      chk("cross_ret_busy",  32'(busy),      32'h0);
      rsp_ready = 2'b00;
      step();
      chk("cross_gnt1", 32'(gnt), 32'h2);
      req = 2'b00;
      step();
      chk("cross_valid1", 32'(rsp_valid), 32'h2);
      chk("cross_data1",  32'(rsp_data),  32'h1);
      rsp_ready = 2'b10;
      step();
      rsp_ready = 2'b00;

      // Simultaneous requests held high with both readies high
`ifdef LU_ARB_RR_EN
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      reset_pulse();
      req = 2'b11;
      rsp_ready = 2'b11;
      for (int g = 0; g < 4; g++) begin
         found = 1'b0;
         for (int k = 0; k < 6 && !found; k++) begin
            step();
            if (gnt != 2'b00) found = 1'b1;
         end
         chk($sformatf("sim_gnt%0d", g), 32'(gnt), 32'(exp_seq[g]));
      end
      req = 2'b00;
      for (int k = 0; k < 4; k++) step();
      chk("sim_end_busy",  32'(busy),      32'h0);
      chk("sim_end_valid", 32'(rsp_valid), 32'h0);
      rsp_ready = 2'b00;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
